// File: rtl/load_use_scoreboard.sv
// Per-register in-flight writer scoreboard for decode: stalls a consumer whose
// source is the destination of an outstanding load, or an issue that would overflow a register's writer count.
module load_use_scoreboard #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue_valid,
    input  logic             i_issue_uses_rw,
    input  logic [4:0]       i_issue_rw_addr,
    input  logic             i_issue_is_load,
    input  logic             i_load_done,
    input  logic [4:0]       i_load_rw_addr,
    input  logic             i_wb_valid,
    input  logic             i_wb_uses_rw,
    input  logic [4:0]       i_wb_rw_addr,
    input  logic             i_flush,
    input  logic             i_uses_rs,
    input  logic             i_uses_rt,
    input  logic [4:0]       i_rs_addr,
    input  logic [4:0]       i_rt_addr,
    output logic             o_stall,
    output logic             o_rs_pending,
    output logic             o_rt_pending,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int unsigned PW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_INFLIGHT);

    logic [PW-1:0]       cnt_q [NUM_REGS];
    logic [PW-1:0]       cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] ld_q;
    logic [NUM_REGS-1:0] ld_d;
    logic [CNT_W-1:0]    stall_cycles_q;
    logic [CNT_W-1:0]    stall_cycles_d;

    logic issue_req;
    logic issue_go;
    logic retire_go;
    logic same_rw;
    logic rs_stall;
    logic rt_stall;
    logic dst_full;
    logic stall_c;

    // Hazard detection; a load completing this cycle releases its consumer immediately.
    always_comb begin
        issue_req = i_issue_valid & i_issue_uses_rw & (i_issue_rw_addr != 5'd0);
        retire_go = i_wb_valid & i_wb_uses_rw & (i_wb_rw_addr != 5'd0);
        same_rw   = retire_go & (i_wb_rw_addr == i_issue_rw_addr);
        dst_full  = issue_req & (cnt_q[i_issue_rw_addr] == PMAX) & ~same_rw;
        rs_stall  = i_uses_rs & (i_rs_addr != 5'd0) & ld_q[i_rs_addr]
                    & ~(i_load_done & (i_load_rw_addr == i_rs_addr));
        rt_stall  = i_uses_rt & (i_rt_addr != 5'd0) & ld_q[i_rt_addr]
                    & ~(i_load_done & (i_load_rw_addr == i_rt_addr));
        stall_c   = rs_stall | rt_stall | dst_full;
        issue_go  = issue_req & ~stall_c;
    end

    assign o_stall        = stall_c;
    assign o_rs_pending   = i_uses_rs & (i_rs_addr != 5'd0) & (cnt_q[i_rs_addr] != '0);
    assign o_rt_pending   = i_uses_rt & (i_rt_addr != 5'd0) & (cnt_q[i_rt_addr] != '0);
    assign o_stall_cycles = stall_cycles_q;

    // Next-state: load_done, then issue (wins on ld), then retire; flush overrides everything.
    always_comb begin
        cnt_d          = cnt_q;
        ld_d           = ld_q;
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_c);

        if (i_load_done) begin
            ld_d[i_load_rw_addr] = 1'b0;
        end
        if (issue_go) begin
            ld_d[i_issue_rw_addr] = i_issue_is_load;
            if (!same_rw) begin
                cnt_d[i_issue_rw_addr] = cnt_q[i_issue_rw_addr] + PW'(1);
            end
        end
        if (retire_go && !(issue_go && same_rw) && (cnt_q[i_wb_rw_addr] != '0)) begin
            cnt_d[i_wb_rw_addr] = cnt_q[i_wb_rw_addr] - PW'(1);
        end
        if (i_flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_d[r] = '0;
            end
            ld_d = '0;
        end
        cnt_d[0] = '0;
        ld_d[0]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            ld_q           <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            ld_q           <= ld_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: hand-computed expectations checked
// with immediate assertions a settle delay after each input change or clock edge.
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_issue_valid, i_issue_uses_rw, i_issue_is_load;
    logic [4:0]  i_issue_rw_addr;
    logic        i_load_done;
    logic [4:0]  i_load_rw_addr;
    logic        i_wb_valid, i_wb_uses_rw;
    logic [4:0]  i_wb_rw_addr;
    logic        i_flush;
    logic        i_uses_rs, i_uses_rt;
    logic [4:0]  i_rs_addr, i_rt_addr;
    logic        o_stall, o_rs_pending, o_rt_pending;
    logic [31:0] o_stall_cycles;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    load_use_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .i_issue_valid(i_issue_valid), .i_issue_uses_rw(i_issue_uses_rw),
        .i_issue_rw_addr(i_issue_rw_addr), .i_issue_is_load(i_issue_is_load),
        .i_load_done(i_load_done), .i_load_rw_addr(i_load_rw_addr),
        .i_wb_valid(i_wb_valid), .i_wb_uses_rw(i_wb_uses_rw), .i_wb_rw_addr(i_wb_rw_addr),
        .i_flush(i_flush),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .o_stall(o_stall), .o_rs_pending(o_rs_pending), .o_rt_pending(o_rt_pending),
        .o_stall_cycles(o_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_issue_valid = 0; i_issue_uses_rw = 0; i_issue_rw_addr = 0; i_issue_is_load = 0;
        i_load_done = 0; i_load_rw_addr = 0;
        i_wb_valid = 0; i_wb_uses_rw = 0; i_wb_rw_addr = 0;
        i_flush = 0;
        i_uses_rs = 0; i_uses_rt = 0; i_rs_addr = 0; i_rt_addr = 0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic is_load);
        i_issue_valid = 1; i_issue_uses_rw = 1; i_issue_rw_addr = a; i_issue_is_load = is_load;
    endtask

    task automatic retire(input logic [4:0] a);
        i_wb_valid = 1; i_wb_uses_rw = 1; i_wb_rw_addr = a;
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("reset_stall", 32'(o_stall), 0);
        check("reset_rs_pend", 32'(o_rs_pending), 0);
        check("reset_counter", o_stall_cycles, 0);

        // Load r5, consumer stalls 4 cycles, load_done releases in the same cycle
        tick(); issue(5'd5, 1);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd5;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin i_load_done = 1; i_load_rw_addr = 5'd6; end
            else i_load_done = 0;
            #1 check("load_hold_stall", 32'(o_stall), 1);
            check("load_hold_pend", 32'(o_rs_pending), 1);
            tick();
        end
        i_load_done = 0;
        check("hold_counter4", o_stall_cycles, 4);
        i_load_done = 1; i_load_rw_addr = 5'd5;
        #1 check("load_bypass_release", 32'(o_stall), 0);
        tick(); i_load_done = 0;
        #1 check("after_done_stall", 32'(o_stall), 0);
        check("after_done_counter", o_stall_cycles, 4);
        check("after_done_pend", 32'(o_rs_pending), 1);
        retire(5'd5);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd5;
        #1 check("r5_retired_pend", 32'(o_rs_pending), 0);

        // ALU write to r7: pending but no stall
        idle(); issue(5'd7, 0);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd7; i_uses_rt = 1; i_rt_addr = 5'd7;
        #1 check("alu_no_stall", 32'(o_stall), 0);
        check("alu_rs_pend", 32'(o_rs_pending), 1);
        check("alu_rt_pend", 32'(o_rt_pending), 1);
        retire(5'd7);
        tick(); i_wb_valid = 0; i_wb_uses_rw = 0;
        #1 check("alu_retired_rt", 32'(o_rt_pending), 0);

        // Three writers to r3, fourth blocked unless r3 retires that cycle
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(5'd3, 0);
            tick();
        end
        #1 check("r3_full_stall", 32'(o_stall), 1);
        retire(5'd3);
        #1 check("r3_full_retire_ok", 32'(o_stall), 0);
        tick(); idle(); issue(5'd3, 0);
        #1 check("r3_still_full", 32'(o_stall), 1);
        idle();
        for (int i = 0; i < 3; i++) begin
            retire(5'd3);
            tick();
        end
        idle(); i_uses_rs = 1; i_rs_addr = 5'd3;
        #1 check("r3_drained_pend", 32'(o_rs_pending), 0);
        retire(5'd3);
        tick(); idle(); issue(5'd3, 0); i_uses_rs = 1; i_rs_addr = 5'd3;
        #1 check("r3_no_underflow_stall", 32'(o_stall), 0);
        check("r3_no_underflow_pend", 32'(o_rs_pending), 0);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd3;
        #1 check("r3_one_pend", 32'(o_rs_pending), 1);
        retire(5'd3);
        tick(); idle();

        // Register 0 is never tracked
        issue(5'd0, 1);
        tick(); idle(); i_uses_rs = 1; i_uses_rt = 1;
        #1 check("r0_stall", 32'(o_stall), 0);
        check("r0_rs_pend", 32'(o_rs_pending), 0);
        check("r0_rt_pend", 32'(o_rt_pending), 0);

        // Flush beats a simultaneous issue
        idle(); issue(5'd9, 1);
        tick(); idle(); i_uses_rt = 1; i_rt_addr = 5'd9;
        #1 check("r9_stall", 32'(o_stall), 1);
        idle(); i_flush = 1; issue(5'd9, 1);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd9; i_uses_rt = 1; i_rt_addr = 5'd9;
        #1 check("flush_stall", 32'(o_stall), 0);
        check("flush_rs_pend", 32'(o_rs_pending), 0);
        check("flush_counter_kept", o_stall_cycles, 4);

        // Async reset mid-stall
        idle(); issue(5'd2, 1);
        tick(); idle(); i_uses_rs = 1; i_rs_addr = 5'd2;
        repeat (6) tick();
        check("pre_reset_counter", o_stall_cycles, 10);
        check("pre_reset_stall", 32'(o_stall), 1);
        #1 rst_n = 0;
        #1 check("async_reset_stall", 32'(o_stall), 0);
        check("async_reset_counter", o_stall_cycles, 0);
        check("async_reset_pend", 32'(o_rs_pending), 0);
        rst_n = 1;
        tick();
        #1 check("post_reset_stall", 32'(o_stall), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Tracks every destination register written by instructions in flight between issue (decode → EX) and write-back, and tells decode when a source operand cannot yet be supplied by forwarding. It is the producer-side complement of the forwarding path: forwarding muxes values already on the EX/MEM/WB result buses, and this block guarantees a consumer never issues before its value exists on one of them. It sits beside decode and drives the decode/issue stall, replacing the single-cycle load-use check with one that covers multi-cycle D-cache misses.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is never tracked.
- MAX_INFLIGHT, 3, writers allowed in flight per register (EX, MEM, WB).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_issue_valid  in  1  an instruction leaves decode this cycle.
- i_issue_uses_rw  in  1  issuing instruction writes a register.
- i_issue_rw_addr  in  5  destination register of issuing instruction.
- i_issue_is_load  in  1  issuing instruction is a memory load.
- i_load_done  in  1  a load's data is valid on the MEM result bus this cycle.
- i_load_rw_addr  in  5  destination of the completing load.
- i_wb_valid  in  1  an instruction retires in WB this cycle.
- i_wb_uses_rw  in  1  retiring instruction writes a register.
- i_wb_rw_addr  in  5  destination of retiring instruction.
- i_flush  in  1  squash all in-flight instructions.
- i_uses_rs / i_uses_rt  in  1 each  decode operand use flags.
- i_rs_addr / i_rt_addr  in  5 each  decode source registers.
- o_stall  out  1  decode must not issue this cycle.
- o_rs_pending / o_rt_pending  out  1 each  source has at least one in-flight writer.
- o_stall_cycles  out  CNT_W  count of cycles with o_stall=1.

## Operation
- Per register r (1..31): pending count cnt[r] (2 bits, 0..MAX_INFLIGHT) and load flag ld[r] (youngest writer is a load whose data has not appeared).
- Issue (i_issue_valid & i_issue_uses_rw & addr≠0 & ~o_stall): cnt +1; ld ← i_issue_is_load.
- Retire (i_wb_valid & i_wb_uses_rw & addr≠0): cnt −1. Issue and retire to same register in same cycle: cnt unchanged, ld updated from issue.
- Load done: ld[i_load_rw_addr] ← 0 unless a new issue to the same register occurs that cycle (issue wins).
- Retire with cnt=0 is a protocol error: cnt stays 0 (no underflow); ld unaffected.
- Stall conditions (any): source s used, s≠0, ld[s]=1 and not (i_load_done & i_load_rw_addr==s); or issuing destination d has cnt[d]==MAX_INFLIGHT and no same-cycle retire of d.
- o_rs_pending = i_uses_rs & rs≠0 & cnt[rs]≠0; likewise rt.
- Flush: all cnt and ld cleared next edge; flush beats issue/retire/load_done in same cycle. o_stall_cycles not cleared by flush.
- o_stall_cycles increments each cycle o_stall=1, wraps at 2^CNT_W.

## Timing
- State registered; o_stall, o_rs_pending, o_rt_pending combinational from state and current inputs.
- Issue at edge N → dependent consumer sees stall in cycle N+1 (if load) until load_done.
- Load-done bypass: consumer stalled in cycle with i_load_done for its source de-asserts stall in that same cycle (zero-cycle release).
- Reset (asynchronous, rst_n=0): cnt, ld all 0, o_stall_cycles 0; outputs o_stall=0, pending=0 immediately. Reset mid-miss discards all state.

## Test plan
- Load r5 issued, next decode uses rs=5: o_stall=1 cycle after issue; hold 4 cycles; assert i_load_done with addr 5 → o_stall=0 same cycle; o_stall_cycles=4.
- ALU write to r7 then consumer of r7: o_stall=0, o_rs_pending=1; after WB retire, o_rs_pending=0.
- Three writers to r3 in flight, fourth issue attempt to r3: o_stall=1; same cycle WB retires r3 → o_stall=0, cnt stays 3.
- Register 0: load to r0 then consumer of r0 → never stalls, pending=0.
- Load r9 pending, i_flush with simultaneous issue to r9 → next cycle cnt[9]=0, ld[9]=0, consumer of r9 no stall.
- rst_n low mid-stall (load r2 pending, counter=10) → o_stall=0 and o_stall_cycles=0 immediately, without a clock edge.
